led_pattern_sequencer: RTL

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a small pattern RAM played out manually, wrapping, bouncing or once.
// led_out is registered (one cycle behind the read address); no backpressure, steps are paced by step_div_i.
module led_pattern_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int DIV_WIDTH  = 24
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [1:0]            mode_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DIV_WIDTH-1:0]  step_div_i,
    output logic [DATA_WIDTH-1:0] led_out,
    output logic [ADDR_WIDTH-1:0] cur_addr_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_MANUAL  = 2'b00;
    localparam logic [1:0] MODE_WRAP    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_led;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_dir_up;
    logic [DIV_WIDTH-1:0]  r_cnt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic [1:0]            r_mode;
    logic                  w_step;
    logic                  w_start;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic                  w_dir_nxt;
    logic                  w_busy;
    logic                  w_done;

    assign w_step  = (r_cnt == r_div);
    assign w_start = (mode_i != MODE_MANUAL) && start_i && !stop_i;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_step && (r_mode == MODE_ONESHOT) && (r_ptr == LAST_ADDR)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == S_RUN);
        w_done = (r_state == S_DONE);
    end

    // Pointer movement for one step; one-shot parks on the last word while the FSM exits.
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_dir_nxt = r_dir_up;
        case (r_mode)
            MODE_WRAP: begin
                w_ptr_nxt = (r_ptr == LAST_ADDR) ? '0 : r_ptr + 1'b1;
            end
            MODE_BOUNCE: begin
                if (r_dir_up) begin
                    if (r_ptr == LAST_ADDR) begin
                        w_ptr_nxt = LAST_ADDR - 1'b1;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end else begin
                    if (r_ptr == '0) begin
                        w_ptr_nxt = ADDR_WIDTH'(1);
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = r_ptr - 1'b1;
                    end
                end
            end
            MODE_ONESHOT: begin
                if (r_ptr != LAST_ADDR) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: w_ptr_nxt = r_ptr;
        endcase
    end

    // Pattern storage survives reset; reads below see the pre-write word.
    always_ff @(posedge sys_clk) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_led    <= '0;
            r_ptr    <= '0;
            r_dir_up <= 1'b1;
            r_cnt    <= '0;
            r_div    <= '0;
            r_mode   <= MODE_MANUAL;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mode_i == MODE_MANUAL) begin
                        r_led <= r_mem[addr_i];
                    end else if (w_start) begin
                        r_mode   <= mode_i;
                        r_div    <= step_div_i;
                        r_ptr    <= '0;
                        r_dir_up <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (!stop_i) begin
                        r_led <= r_mem[r_ptr];
                        if (w_step) begin
                            r_cnt    <= '0;
                            r_ptr    <= w_ptr_nxt;
                            r_dir_up <= w_dir_nxt;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign led_out    = r_led;
    assign cur_addr_o = r_ptr;
    assign busy_o     = w_busy;
    assign done_o     = w_done;

endmodule
